// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT transmit/receive control blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usrt_pkg;

  // Default maximum frame width and the two selectable frame lengths.
  localparam int DW_DEF    = 8;
  localparam int LEN_FULL  = DW_DEF;
  localparam int LEN_SHORT = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/usrt_clk_sync.sv
// Synchronizes the external serial bit clock into clk and emits a rising-edge tick.
// Latency: tick is high in the clk cycle SYNC_STAGES edges after the rise (acted on at edge SYNC_STAGES+1), +/-1 clk.
// Backpressure: none; one tick per usrt_clk rise, consumer must act or miss it.
// Ports: clk/rst (async active-high), async_in = raw usrt_clk, tick = one-clk pulse.
module usrt_clk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  // Rising edge of the synchronized clock: new level high, previous level low.
  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/usrt_tx_sched.sv
// Two-requester round-robin frame scheduler driving the USRT RTS/TXD pins, LSB first.
// Latency: gnt pulses 1 clk after req is seen in IDLE, RTS rises on the next clk, bits follow usrt_clk ticks.
// Backpressure: requesters hold req until gnt; new requests wait in IDLE while a frame or gap is in progress.
// Ports: clk, rst, usrt_clk, req[1:0], data0/data1[DW], len_sel -> gnt[1:0], busy, done, RTS, TXD.
module usrt_tx_sched
  import usrt_pkg::*;
#(
  parameter int DW          = LEN_FULL,
  parameter int GAP_TICKS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          usrt_clk,
  input  logic [1:0]    req,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic          len_sel,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          done,
  output logic          RTS,
  output logic          TXD
);

  localparam int CW = $clog2(DW + 1);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  logic tick;

  usrt_clk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (usrt_clk),
    .tick     (tick)
  );

  state_e        state_q, state_d;
  logic          sel_q, sel_d;      // requester chosen in IDLE, served in LOAD
  logic          last_q, last_d;    // last requester granted
  logic [DW-1:0] sr_q, sr_d;        // shifts right; bit 0 is always the next bit out
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] bit_q, bit_d;      // bits already placed on TXD this frame
  logic [GW-1:0] gap_q, gap_d;
  logic          rts_q, rts_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    sr_d    = sr_q;
    len_d   = len_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    rts_d   = rts_q;
    txd_d   = txd_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie the requester that was not served last wins.
          sel_d   = (req == 2'b11) ? ~last_q : req[1];
          state_d = LOAD;
        end
      end
      LOAD: begin
        sr_d    = sel_q ? data1 : data0;
        len_d   = len_sel ? CW'(LEN_SHORT) : CW'(DW);
        last_d  = sel_q;
        rts_d   = 1'b1;
        state_d = ARM;
      end
      ARM: begin
        if (tick) begin
          txd_d   = sr_q[0];
          sr_d    = sr_q >> 1;
          bit_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_q == len_q) begin
            txd_d   = 1'b1;
            rts_d   = 1'b0;
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            txd_d = sr_q[0];
            sr_d  = sr_q >> 1;
            bit_d = bit_q + CW'(1);
          end
        end
      end
      GAP: begin
        if (GAP_TICKS == 0) begin
          state_d = IDLE;
        end else if (tick) begin
          gap_d = gap_q + GW'(1);
          if (gap_q + GW'(1) == GW'(GAP_TICKS)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      sr_q    <= '0;
      len_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      rts_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      sr_q    <= sr_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      rts_q   <= rts_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign gnt  = (state_q == LOAD) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign RTS  = rts_q;
  assign TXD  = txd_q;

endmodule

// File: tb/tb_usrt_tx_sched.sv
// Scoreboard bench for usrt_tx_sched: expected frames queued at stimulus time, checked as bits appear.
// Latency: n/a.
// Backpressure: n/a.
module tb_usrt_tx_sched;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
    logic [3:0] len;
  } exp_t;

  logic       clk = 1'b0;
  logic       usrt_clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] data0, data1;
  logic       len_sel;
  logic [1:0] gnt;
  logic       busy, done, RTS, TXD;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_d0;
  int   n_err = 0, n_chk = 0;
  int   gnt_cnt = 0, frames_done = 0, done_cnt = 0, idle_bad = 0;
  bit   idle_watch = 1'b0;
  bit   model_last = 1'b1;
  int   d_base;

  usrt_tx_sched dut (
    .clk      (clk),
    .rst      (rst),
    .usrt_clk (usrt_clk),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .len_sel  (len_sel),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .RTS      (RTS),
    .TXD      (TXD)
  );

  always #5  clk = ~clk;
  always #50 usrt_clk = ~usrt_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  always @(negedge clk)
    if (idle_watch && (RTS !== 1'b0 || TXD !== 1'b1 || busy !== 1'b0 || gnt !== 2'b00))
      idle_bad++;

  // Reference model: round-robin winner bookkeeping and expected frame contents.
  task automatic expect_frame(input bit who, input logic [7:0] d, input logic ls);
    exp_t e;
    e.g   = who ? 2'b10 : 2'b01;
    e.d   = d;
    e.len = ls ? 4'd6 : 4'd8;
    exp_q.push_back(e);
    model_last = who;
  endtask

  task automatic check_frame(input exp_t e, input int d0);
    @(posedge usrt_clk);
    for (int i = 0; i < int'(e.len); i++) begin
      #60;
      if (rst) return;
      chk($sformatf("bit%0d_rts", i), RTS, 1);
      chk($sformatf("bit%0d_txd", i), TXD, e.d[i]);
      @(posedge usrt_clk);
    end
    #60;
    if (rst) return;
    chk("end_rts", RTS, 0);
    chk("end_txd", TXD, 1);
    chk("done_once", done_cnt, d0 + 1);
    frames_done++;
    @(posedge usrt_clk);
    #60;
    if (rst) return;
    chk("gap_busy", busy, 1);
    @(posedge usrt_clk);
    for (int k = 0; k < 20 && busy !== 1'b0; k++) @(negedge clk);
    chk("busy_drop", busy, 0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && gnt !== 2'b00) begin
        gnt_cnt++;
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", gnt, 0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_d0 = done_cnt;
          chk("gnt_who", gnt, mon_e.g);
          chk("rts_in_load", RTS, 0);
          @(negedge clk);
          chk("gnt_pulse", gnt, 0);
          chk("rts_rise", RTS, 1);
          check_frame(mon_e, mon_d0);
        end
      end
    end
  end

  task automatic wait_gnts(input int target);
    for (int k = 0; k < 400 && gnt_cnt < target; k++) @(negedge clk);
    chk("gnt_wait", gnt_cnt, target);
  endtask

  task automatic wait_frames(input int target);
    for (int k = 0; k < 3000 && frames_done < target; k++) @(negedge clk);
    chk("frame_wait", frames_done, target);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 500 && busy !== 1'b0; k++) @(negedge clk);
    chk("idle_wait", busy, 0);
  endtask

  initial begin : stim
    rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0; len_sel = 1'b0;
    #23;
    chk("rst_rts", RTS, 0);
    chk("rst_txd", TXD, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    #20 rst = 1'b0;

    // Idle with no requests for 20 bit periods.
    idle_watch = 1'b1;
    repeat (20) @(posedge usrt_clk);
    idle_watch = 1'b0;
    chk("idle_stable", idle_bad, 0);

    // Single 8-bit frame from requester 0.
    @(negedge usrt_clk);
    data0 = 8'hA5; len_sel = 1'b0;
    expect_frame(1'b0, 8'hA5, 1'b0);
    req = 2'b01;
    wait_gnts(1);
    req = 2'b00;
    wait_frames(1);
    wait_idle();

    // Short frame from requester 1; top two bits must never appear.
    @(negedge usrt_clk);
    data1 = 8'hFF; len_sel = 1'b1;
    expect_frame(1'b1, 8'hFF, 1'b1);
    req = 2'b10;
    wait_gnts(2);
    req = 2'b00;
    wait_frames(2);
    wait_idle();
    len_sel = 1'b0;

    // Both requesting continuously: grants alternate.
    @(negedge usrt_clk);
    data0 = 8'h0F; data1 = 8'hF0;
    for (int n = 0; n < 3; n++) begin
      automatic bit w = ~model_last;
      expect_frame(w, w ? 8'hF0 : 8'h0F, 1'b0);
    end
    req = 2'b11;
    wait_gnts(5);
    req = 2'b00;
    wait_frames(5);
    wait_idle();

    // Reset in the middle of a frame.
    @(negedge usrt_clk);
    data0 = 8'hC3;
    expect_frame(1'b0, 8'hC3, 1'b0);
    req = 2'b01;
    wait_gnts(6);
    req = 2'b00;
    repeat (4) @(posedge usrt_clk);
    #62;
    d_base = done_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_rts", RTS, 0);
    chk("midrst_txd", TXD, 1);
    chk("midrst_busy", busy, 0);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    chk("midrst_no_done", done_cnt, d_base);
    repeat (30) @(negedge clk);
    chk("no_regrant", gnt_cnt, 6);
    chk("post_rst_idle", busy, 0);

    // Fresh frame after reset starts from bit 0.
    @(negedge usrt_clk);
    data0 = 8'h3C;
    expect_frame(1'b0, 8'h3C, 1'b0);
    req = 2'b01;
    wait_gnts(7);
    req = 2'b00;
    wait_frames(6);
    wait_idle();

    // Inputs changed mid-frame are ignored; request during gap waits for IDLE.
    @(negedge usrt_clk);
    data0 = 8'h96; len_sel = 1'b0;
    expect_frame(1'b0, 8'h96, 1'b0);
    req = 2'b01;
    wait_gnts(8);
    req = 2'b00;
    d_base = done_cnt;
    repeat (3) @(posedge usrt_clk);
    #30;
    len_sel = 1'b1; data0 = 8'h00;
    for (int k = 0; k < 2000 && done_cnt == d_base; k++) @(negedge clk);
    chk("f_done_seen", done_cnt, d_base + 1);
    data1 = 8'h5A;
    expect_frame(1'b1, 8'h5A, 1'b1);
    req = 2'b10;
    for (int k = 0; k < 500 && busy !== 1'b0; k++) @(negedge clk);
    chk("gap_busy_fall", busy, 0);
    @(negedge clk);
    chk("gnt_after_gap", gnt, 2'b10);
    req = 2'b00;
    wait_frames(8);
    wait_idle();
    chk("gnt_total", gnt_cnt, 9);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
